axi_lite_init_seq: RTL
======================

Name: axi_lite_init_seq

Overview:
- Boot-time configuration sequencer. It is an AXI-Lite master that walks a table of (address, data) entries and issues one AXI-Lite write per entry.
- Occupies one slave port of the AXI-Lite crossbar, next to the CPU. It programs the RAM/REGF windows and the APB window (0x0013_0000..0x0013_FFFF, e.g. i2c at 0x0013_0100) before the CPU is released.
- Reports busy/done/error with the index of the failing entry.

Parameters:
- AXI_ADDR_WIDTH, 32, address width; same as the crossbar.
- AXI_DATA_WIDTH, 32, data width; strobe width = AXI_DATA_WIDTH/8.
- NO_ENTRIES, 16, table depth; IDX_W = $clog2(NO_ENTRIES).
- TIMEOUT_CYCLES, 256, maximum cycles to wait for B (or R) after the request handshake completes.

Ports:
- ACLKMST_ACLK  in  1  clock.
- ARSTnMS_ACLK  in  1  asynchronous active-low reset.
- start_i  in  1  start pulse; sampled only in IDLE/DONE/ERR.
- tbl_num_i  in  IDX_W+1  number of valid entries (0..NO_ENTRIES).
- tbl_idx_o  out  IDX_W  current entry index.
- tbl_addr_i  in  AXI_ADDR_WIDTH  entry address; combinational from tbl_idx_o.
- tbl_data_i  in  AXI_DATA_WIDTH  entry write data; combinational from tbl_idx_o.
- aw_addr_o/aw_prot_o/aw_valid_o  out  ADDR/3/1  write address channel; aw_prot_o = 3'b000.
- aw_ready_i  in  1  write address ready.
- w_data_o/w_strb_o/w_valid_o  out  DATA/STRB/1  write data channel; w_strb_o is all ones.
- w_ready_i  in  1  write data ready.
- b_resp_i  in  2  write response.
- b_valid_i  in  1  write response valid.
- b_ready_o  out  1  write response ready.
- ar_addr_o/ar_prot_o/ar_valid_o  out  ADDR/3/1  read address channel; held at 0 unless INIT_SEQ_VERIFY_EN.
- ar_ready_i  in  1  read address ready.
- r_data_i/r_resp_i/r_valid_i  in  DATA/2/1  read data channel.
- r_ready_o  out  1  read data ready.
- busy_o  out  1  sequence in progress.
- done_o  out  1  sequence completed without error.
- err_o  out  1  sequence stopped on error.
- err_code_o  out  2  0 none, 1 bad BRESP, 2 timeout, 3 verify fail.
- err_idx_o  out  IDX_W  index of the failing entry.

Behaviour:
- Reset (async, active-low) clears all state and outputs to 0: FSM=IDLE, tbl_idx_o, all valid/ready outputs, busy_o, done_o, err_o, err_code_o, err_idx_o.
- Reset mid-transaction abandons the transfer; the crossbar shares this reset.

FSM: IDLE, FETCH, WRITE, WAIT_B, [RD_AR, RD_R], DONE, ERR.
- IDLE/DONE/ERR + start_i:
  - tbl_num_i==0 → DONE.
  - otherwise → FETCH; idx=0, busy_o=1, done_o/err_o/err_code_o cleared.
- start_i while busy_o=1 is ignored.
- FETCH (1 cycle): register tbl_addr_i/tbl_data_i into aw_addr_o/w_data_o (and ar_addr_o) → WRITE.
- WRITE:
  - aw_valid_o and w_valid_o assert together.
  - Each channel drops its valid only after its own handshake; handshakes may complete in either order or in the same cycle.
  - Valids never deassert before their handshake. There is no timeout in this state.
  - Both handshakes done → WAIT_B.
- WAIT_B:
  - b_ready_o=1; timeout counter runs from 0.
  - b_valid_i with BRESP==OKAY → next entry.
  - b_valid_i with BRESP!=OKAY → ERR, code 1.
  - Counter reaches TIMEOUT_CYCLES-1 without b_valid_i → ERR, code 2.
- Next entry: idx==tbl_num_i-1 → DONE (done_o=1, busy_o=0); else idx+1 → FETCH.
- ERR:
  - err_o=1, busy_o=0, err_idx_o = failing idx.
  - b_ready_o and r_ready_o stay 1 so a late response is accepted and discarded (no crossbar deadlock).
- DONE/ERR outputs hold until the next start_i.
- Latency with all readys high and B returned in the first WAIT_B cycle:
  - start_i sampled at T; done_o=1 at T+1+3N.
  - Without verify, each entry takes 3 cycles: FETCH, WRITE, WAIT_B.
- The timeout counter is IDX-independent, $clog2(TIMEOUT_CYCLES) wide, and cleared on every state entry.

Optional Feature:
- INIT_SEQ_VERIFY_EN defined:
  - After an OKAY B the FSM goes WAIT_B → RD_AR: ar_valid_o=1 with the same address until ar_ready_i.
  - Then RD_R: r_ready_o=1 and the timeout counter runs.
  - RRESP!=OKAY or r_data_i!=written data → ERR, code 3. R timeout → ERR, code 2.
  - Each entry takes 5 cycles; done_o at T+1+5N.
- Undefined: RD_AR/RD_R are absent, ar_valid_o=0, r_ready_o=1 constantly, and code 3 is never produced.

Decomposition:
- Package axi_lite_init_seq_pkg:
  - state_e enum.
  - err_code_e enum: ERR_NONE/ERR_BRESP/ERR_TIMEOUT/ERR_VERIFY.
  - AXI RESP_OKAY constant.
- One natural sub-module: axi_lite_init_seq_timeout, the per-transaction saturating counter with clear and expire.

Test Plan:
- tbl_num_i=3, writes to 0x0013_0000/0x0013_0100/0x0000_0010, readys high, B OKAY next cycle → three AW/W pairs in order, done_o=1 exactly at T+10, err_o=0.
- aw_ready_i delayed 4 cycles, w_ready_i immediate → w_valid_o drops after 1 cycle, aw_valid_o held 5 cycles with stable address, no duplicate write.
- BRESP=SLVERR on entry 1 of 3 → err_o=1, err_code_o=1, err_idx_o=1, entry 2 never issued.
- No B for 256 cycles on entry 0 → err_code_o=2; late b_valid_i is accepted by b_ready_o=1; a subsequent start_i reruns cleanly.
- tbl_num_i=0 → done_o=1 at T+1, no AXI activity; start_i pulsed while busy → ignored.
- (INIT_SEQ_VERIFY_EN) readback returns 0xDEAD_BEEF vs written 0x1234_5678 → err_code_o=3 at that entry's index.

Source files
------------

// File: rtl/axi_lite_init_seq_pkg.sv
// Shared types and constants for the boot-time AXI-Lite configuration sequencer.
package axi_lite_init_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWrite,
    StWaitB,
    StRdAr,
    StRdR,
    StDone,
    StErr
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_BRESP   = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_VERIFY  = 2'd3
  } err_code_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi_lite_init_seq_if.sv
// AXI-Lite channel bundle between the init sequencer (master) and the crossbar port (slave).
interface axi_lite_init_seq_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32
);
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

  logic [AXI_ADDR_WIDTH-1:0] aw_addr_o;
  logic [2:0]                aw_prot_o;
  logic                      aw_valid_o;
  logic                      aw_ready_i;
  logic [AXI_DATA_WIDTH-1:0] w_data_o;
  logic [STRB_W-1:0]         w_strb_o;
  logic                      w_valid_o;
  logic                      w_ready_i;
  logic [1:0]                b_resp_i;
  logic                      b_valid_i;
  logic                      b_ready_o;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr_o;
  logic [2:0]                ar_prot_o;
  logic                      ar_valid_o;
  logic                      ar_ready_i;
  logic [AXI_DATA_WIDTH-1:0] r_data_i;
  logic [1:0]                r_resp_i;
  logic                      r_valid_i;
  logic                      r_ready_o;

  modport master (
    output aw_addr_o, aw_prot_o, aw_valid_o, w_data_o, w_strb_o, w_valid_o, b_ready_o,
    output ar_addr_o, ar_prot_o, ar_valid_o, r_ready_o,
    input  aw_ready_i, w_ready_i, b_resp_i, b_valid_i, ar_ready_i, r_data_i, r_resp_i, r_valid_i
  );

  modport slave (
    input  aw_addr_o, aw_prot_o, aw_valid_o, w_data_o, w_strb_o, w_valid_o, b_ready_o,
    input  ar_addr_o, ar_prot_o, ar_valid_o, r_ready_o,
    output aw_ready_i, w_ready_i, b_resp_i, b_valid_i, ar_ready_i, r_data_i, r_resp_i, r_valid_i
  );

endinterface

// File: rtl/axi_lite_init_seq_timeout.sv
// Per-transaction response timeout: saturating counter, cleared on clr, flags the last cycle.
module axi_lite_init_seq_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axi_lite_init_seq.sv
// Boot-time AXI-Lite master writing a table of (address, data) entries, one write per entry.
// Define INIT_SEQ_VERIFY_EN to read back and compare each entry after its write.
module axi_lite_init_seq
  import axi_lite_init_seq_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned NO_ENTRIES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  localparam int unsigned IDX_W         = $clog2(NO_ENTRIES)
) (
  input  logic                      ACLKMST_ACLK,
  input  logic                      ARSTnMS_ACLK,
  input  logic                      start_i,
  input  logic [IDX_W:0]            tbl_num_i,
  output logic [IDX_W-1:0]          tbl_idx_o,
  input  logic [AXI_ADDR_WIDTH-1:0] tbl_addr_i,
  input  logic [AXI_DATA_WIDTH-1:0] tbl_data_i,
  axi_lite_init_seq_if.master       axi,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [1:0]                err_code_o,
  output logic [IDX_W-1:0]          err_idx_o
);

  state_e                    state_q, state_d;
  err_code_e                 err_code_q, err_code_d;
  logic [IDX_W-1:0]          idx_q, idx_d, err_idx_q, err_idx_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] data_q, data_d;
  logic                      aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                      aw_hs, w_hs, last_entry, to_expired;

  assign aw_hs      = axi.aw_valid_o && axi.aw_ready_i;
  assign w_hs       = axi.w_valid_o && axi.w_ready_i;
  assign last_entry = ({1'b0, idx_q} == (tbl_num_i - (IDX_W + 1)'(1)));

  axi_lite_init_seq_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (ACLKMST_ACLK),
    .rst_n  (ARSTnMS_ACLK),
    .clr    (state_d != state_q),
    .en     ((state_q == StWaitB) || (state_q == StRdR)),
    .expired(to_expired)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    data_d     = data_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    err_code_d = err_code_q;
    err_idx_d  = err_idx_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start_i) begin
          err_code_d = ERR_NONE;
          idx_d      = '0;
          state_d    = (tbl_num_i == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        addr_d    = tbl_addr_i;
        data_d    = tbl_data_i;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = StWrite;
      end
      StWrite: begin
        // AW and W complete independently; leave once both have been accepted.
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = StWaitB;
      end
      StWaitB: begin
        if (axi.b_valid_i) begin
          if (axi.b_resp_i != RESP_OKAY) begin
            err_code_d = ERR_BRESP;
            err_idx_d  = idx_q;
            state_d    = StErr;
          end else begin
`ifdef INIT_SEQ_VERIFY_EN
            state_d = StRdAr;
`else
            if (last_entry) begin
              state_d = StDone;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = StFetch;
            end
`endif
          end
        end else if (to_expired) begin
          err_code_d = ERR_TIMEOUT;
          err_idx_d  = idx_q;
          state_d    = StErr;
        end
      end
`ifdef INIT_SEQ_VERIFY_EN
      StRdAr: begin
        if (axi.ar_ready_i) state_d = StRdR;
      end
      StRdR: begin
        if (axi.r_valid_i) begin
          if ((axi.r_resp_i != RESP_OKAY) || (axi.r_data_i != data_q)) begin
            err_code_d = ERR_VERIFY;
            err_idx_d  = idx_q;
            state_d    = StErr;
          end else if (last_entry) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = StFetch;
          end
        end else if (to_expired) begin
          err_code_d = ERR_TIMEOUT;
          err_idx_d  = idx_q;
          state_d    = StErr;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLKMST_ACLK or negedge ARSTnMS_ACLK) begin
    if (!ARSTnMS_ACLK) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      err_code_q <= ERR_NONE;
      err_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      err_code_q <= err_code_d;
      err_idx_q  <= err_idx_d;
    end
  end

  assign axi.aw_addr_o  = addr_q;
  assign axi.aw_prot_o  = 3'b000;
  assign axi.aw_valid_o = (state_q == StWrite) && !aw_done_q;
  assign axi.w_data_o   = data_q;
  assign axi.w_strb_o   = '1;
  assign axi.w_valid_o  = (state_q == StWrite) && !w_done_q;
  // Ready stays high in ERR so a late response still drains through the crossbar.
  assign axi.b_ready_o  = (state_q == StWaitB) || (state_q == StErr);
  assign axi.ar_prot_o  = 3'b000;
`ifdef INIT_SEQ_VERIFY_EN
  assign axi.ar_addr_o  = addr_q;
  assign axi.ar_valid_o = (state_q == StRdAr);
  assign axi.r_ready_o  = (state_q == StRdR) || (state_q == StErr);
`else
  logic unused_rd;
  assign unused_rd      = ^{axi.ar_ready_i, axi.r_data_i, axi.r_resp_i, axi.r_valid_i};
  assign axi.ar_addr_o  = '0;
  assign axi.ar_valid_o = 1'b0;
  assign axi.r_ready_o  = 1'b1;
`endif

  assign tbl_idx_o  = idx_q;
  assign busy_o     = !((state_q == StIdle) || (state_q == StDone) || (state_q == StErr));
  assign done_o     = (state_q == StDone);
  assign err_o      = (state_q == StErr);
  assign err_code_o = err_code_q;
  assign err_idx_o  = err_idx_q;

endmodule
